// File: rtl/mem_arbiter.sv
// N-channel SRAM arbiter: fixed-priority or round-robin grant, ACC_CYC-cycle access, 1-cycle turnaround.
// Grant is combinational in IDLE; memory outputs are registered; min grant spacing ACC_CYC+2 cycles.
module mem_arbiter #(
   parameter int N_CH    = 2,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MODE    = 0,
   parameter int ACC_CYC = 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_en,
   input  logic [N_CH-1:0]          i_req,
   input  logic [N_CH-1:0]          i_wr,
   input  logic [N_CH*ADDR_W-1:0]   i_addr,
   input  logic [N_CH*DATA_W-1:0]   i_wdata,
   output logic [N_CH-1:0]          o_gnt,
   output logic [N_CH-1:0]          o_done,
   output logic [DATA_W-1:0]        o_rdata,
   output logic [ADDR_W-1:0]        o_memAddr,
   output logic                     o_memWr,
   output logic                     o_memEn,
   output logic [DATA_W-1:0]        o_memDataOut,
   output logic                     o_memDataOe,
   input  logic [DATA_W-1:0]        i_memDataIn
);

   localparam int LG_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t          state, state_nxt;
   logic [3:0]      cnt;
   logic [LG_W-1:0] last_gnt, cur, win;
   logic            win_vld, grant;
   int              idx;

   // Winner search: round-robin starts just after the previous winner.
   always_comb begin
      win_vld = 1'b0;
      win     = '0;
      idx     = 0;
      for (int i = 0; i < N_CH; i++) begin
         idx = (MODE == 1) ? (int'(last_gnt) + 1 + i) % N_CH : i;
         if (!win_vld && i_req[idx[LG_W-1:0]]) begin
            win_vld = 1'b1;
            win     = LG_W'(idx);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      o_gnt     = '0;
      grant     = 1'b0;
      case (state)
         IDLE: begin
            if (i_en && win_vld && !i_rst) begin
               grant      = 1'b1;
               o_gnt[win] = 1'b1;
               state_nxt  = ACCESS;
            end
         end
         ACCESS:  if (cnt == 4'd1) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt          <= '0;
         cur          <= '0;
         last_gnt     <= LG_W'(N_CH - 1);
         o_done       <= '0;
         o_rdata      <= '0;
         o_memAddr    <= '0;
         o_memWr      <= 1'b0;
         o_memEn      <= 1'b0;
         o_memDataOut <= '0;
         o_memDataOe  <= 1'b0;
      end else begin
         o_done <= '0;
         if (grant) begin
            cnt          <= 4'(ACC_CYC);
            cur          <= win;
            last_gnt     <= win;
            o_memAddr    <= i_addr[win*ADDR_W +: ADDR_W];
            o_memDataOut <= i_wdata[win*DATA_W +: DATA_W];
            o_memWr      <= i_wr[win];
            o_memDataOe  <= i_wr[win];
            o_memEn      <= 1'b1;
         end else if (state == ACCESS) begin
            if (cnt == 4'd1) begin
               // Last access cycle: capture read data and release the bus for DONE.
               cnt         <= '0;
               o_memEn     <= 1'b0;
               o_memWr     <= 1'b0;
               o_memDataOe <= 1'b0;
               o_done[cur] <= 1'b1;
               if (!o_memWr) o_rdata <= i_memDataIn;
            end else begin
               cnt <= cnt - 4'd1;
            end
         end
      end
   end

endmodule
